daq_page_scheduler: RTL and testbench

- Owns the page ring of the 32K-word DAQ event buffer: allocates write pages, retires read pages, and reports occupancy, full, empty and drops.
- Sequences page-size changes safely. A change request drains the ring, applies the new size and acknowledges.
- Sits in the link clock domain between the event write manager (end-of-event pulses) and the readout side (DMA or register "done with buffer" pulses, already synchronised into this domain).

---
 rtl/daq_pkg.sv | 26 ++
 rtl/daq_page_ring_inc.sv | 32 +++
 rtl/daq_page_scheduler.sv | 166 ++++++++++++++++
 tb/tb_daq_page_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ page ring: page-size encodings, scheduler
// states and the page-count helper.
package daq_pkg;

    localparam logic [1:0] PAGE_512  = 2'd0;
    localparam logic [1:0] PAGE_1024 = 2'd1;
    localparam logic [1:0] PAGE_2048 = 2'd2;

    localparam int unsigned MAX_PAGES = 64;

    typedef enum logic [1:0] {
        SCHED_RUN   = 2'd0,
        SCHED_DRAIN = 2'd1,
        SCHED_APPLY = 2'd2
    } sched_state_e;

    // Encoding 3 is an alias of the largest page size.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? PAGE_2048 : size;
    endfunction

    function automatic int unsigned page_count(input logic [1:0] size);
        return MAX_PAGES >> norm_size(size);
    endfunction

endpackage

// File: rtl/daq_page_ring_inc.sv
// Next value of one ring pointer (modulo page count) and its buffer-address
// overlay, i.e. the page id shifted into address bits [14:9].
module daq_page_ring_inc
    import daq_pkg::*;
#(
    parameter int ID_W = 6
) (
    input  logic [ID_W-1:0] id,
    input  logic [1:0]      page_size,
    input  logic            advance,
    input  logic            zero,
    output logic [ID_W-1:0] id_nxt,
    output logic [ID_W-1:0] overlay_nxt
);

    logic [ID_W-1:0] mask;

    assign mask = ID_W'(page_count(page_size) - 1);

    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        id_nxt = id;
        if (zero) begin
            id_nxt = '0;
        end else if (advance) begin
            id_nxt = (id + 1'b1) & mask;
        end
        overlay_nxt = id_nxt << page_size;
    end

endmodule

// File: rtl/daq_page_scheduler.sv
// Page ring owner for the DAQ event buffer: write/read page allocation,
// occupancy flags, drop counting and drained page-size changes.
module daq_page_scheduler
    import daq_pkg::*;
#(
    parameter int ID_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       page_size_req,
    input  logic             cfg_req,
    output logic             cfg_ack,
    output logic [1:0]       page_size,
    input  logic             wr_done,
    input  logic             rd_done,
    output logic [ID_W-1:0]  w_buf_id,
    output logic [ID_W-1:0]  r_buf_id,
    output logic [ID_W-1:0]  w_overlay,
    output logic [ID_W-1:0]  r_overlay,
    output logic [ID_W-1:0]  nevents,
    output logic             full,
    output logic             empty,
    output logic             draining,
    output logic [CNT_W-1:0] drop_count,
    output logic             underflow
);

    sched_state_e     state_q, state_d;
    logic [1:0]       pend_size_q, pend_size_d;
    logic [1:0]       page_size_q, page_size_d;
    logic [ID_W-1:0]  w_id_q, w_id_d, r_id_q, r_id_d;
    logic [ID_W-1:0]  w_ovl_q, w_ovl_d, r_ovl_q, r_ovl_d;
    logic [ID_W-1:0]  nevents_q, nevents_d, mask_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             underflow_q, underflow_d;
    logic             cfg_ack_q, cfg_ack_d, draining_q, draining_d;
    logic             wr_adv, wr_drop, rd_adv, rd_take, ids_zero;

    daq_page_ring_inc #(.ID_W(ID_W)) u_w_ring (
        .id(w_id_q), .page_size(page_size_q), .advance(wr_adv), .zero(ids_zero),
        .id_nxt(w_id_d), .overlay_nxt(w_ovl_d)
    );

    daq_page_ring_inc #(.ID_W(ID_W)) u_r_ring (
        .id(r_id_q), .page_size(page_size_q), .advance(rd_adv), .zero(ids_zero),
        .id_nxt(r_id_d), .overlay_nxt(r_ovl_d)
    );

    always_comb begin
        state_d     = state_q;
        pend_size_d = pend_size_q;
        page_size_d = page_size_q;
        drop_d      = drop_q;
        underflow_d = underflow_q;
        wr_adv      = 1'b0;
        wr_drop     = 1'b0;
        rd_adv      = 1'b0;
        rd_take     = 1'b0;
        ids_zero    = 1'b0;

        if (clear) begin
            state_d     = SCHED_RUN;
            ids_zero    = 1'b1;
            drop_d      = '0;
            underflow_d = 1'b0;
        end else begin
            unique case (state_q)
                SCHED_RUN: begin
                    wr_adv  = wr_done & ~full_q;
                    wr_drop = wr_done & full_q;
                    rd_take = 1'b1;
                    if (cfg_req) begin
                        pend_size_d = page_size_req;
                        state_d     = SCHED_DRAIN;
                    end
                end
                SCHED_DRAIN: begin
                    wr_drop = wr_done;
                    rd_take = 1'b1;
                    if (cfg_req) pend_size_d = page_size_req;
                    // Writes are frozen here, so the ring empties exactly when
                    // the last remaining page is read back.
                    if (empty_q || (rd_done && nevents_q == ID_W'(1))) begin
                        state_d = SCHED_APPLY;
                    end
                end
                SCHED_APPLY: begin
                    page_size_d = norm_size(pend_size_q);
                    ids_zero    = 1'b1;
                    wr_drop     = wr_done;
                    state_d     = SCHED_RUN;
                end
                default: state_d = SCHED_RUN;
            endcase

            if (rd_take) begin
                rd_adv = rd_done & ~empty_q;
                if (rd_done && empty_q) underflow_d = 1'b1;
            end
            if (wr_drop && drop_q != '1) drop_d = drop_q + 1'b1;
        end

        cfg_ack_d  = ~clear && (state_q == SCHED_APPLY);
        draining_d = (state_d == SCHED_DRAIN);
    end

    always_comb begin
        mask_d    = ID_W'(page_count(page_size_d) - 1);
        nevents_d = (w_id_d - r_id_d) & mask_d;
        full_d    = (((w_id_d + 1'b1) & mask_d) == r_id_d);
        empty_d   = (w_id_d == r_id_d);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCHED_RUN;
            pend_size_q <= PAGE_512;
            page_size_q <= PAGE_512;
            w_id_q      <= '0;
            r_id_q      <= '0;
            w_ovl_q     <= '0;
            r_ovl_q     <= '0;
            nevents_q   <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            drop_q      <= '0;
            underflow_q <= 1'b0;
            cfg_ack_q   <= 1'b0;
            draining_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_size_q <= pend_size_d;
            page_size_q <= page_size_d;
            w_id_q      <= w_id_d;
            r_id_q      <= r_id_d;
            w_ovl_q     <= w_ovl_d;
            r_ovl_q     <= r_ovl_d;
            nevents_q   <= nevents_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            drop_q      <= drop_d;
            underflow_q <= underflow_d;
            cfg_ack_q   <= cfg_ack_d;
            draining_q  <= draining_d;
        end
    end

    assign cfg_ack    = cfg_ack_q;
    assign page_size  = page_size_q;
    assign w_buf_id   = w_id_q;
    assign r_buf_id   = r_id_q;
    assign w_overlay  = w_ovl_q;
    assign r_overlay  = r_ovl_q;
    assign nevents    = nevents_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign draining   = draining_q;
    assign drop_count = drop_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_daq_page_scheduler.sv
// Directed bench for daq_page_scheduler: fill, wrap, drained reconfiguration,
// full+simultaneous events, underflow/clear and asynchronous reset.
module tb_daq_page_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  page_size_req = 2'd0;
    logic        cfg_req = 1'b0;
    logic        cfg_ack;
    logic [1:0]  page_size;
    logic        wr_done = 1'b0;
    logic        rd_done = 1'b0;
    logic [5:0]  w_buf_id, r_buf_id, w_overlay, r_overlay, nevents;
    logic        full, empty, draining, underflow;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    daq_page_scheduler #(.ID_W(6), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .page_size_req(page_size_req), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
        .page_size(page_size), .wr_done(wr_done), .rd_done(rd_done),
        .w_buf_id(w_buf_id), .r_buf_id(r_buf_id),
        .w_overlay(w_overlay), .r_overlay(r_overlay), .nevents(nevents),
        .full(full), .empty(empty), .draining(draining),
        .drop_count(drop_count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, sample 1ns later.
    task automatic step(input logic w, input logic r, input logic c,
                        input logic cr, input logic [1:0] req);
        wr_done = w; rd_done = r; clear = c; cfg_req = cr; page_size_req = req;
        @(posedge clk);
        #1;
        wr_done = 1'b0; rd_done = 1'b0; clear = 1'b0; cfg_req = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_w_id"},     32'(w_buf_id),   32'd0);
        check({pfx, "_r_id"},     32'(r_buf_id),   32'd0);
        check({pfx, "_w_ovl"},    32'(w_overlay),  32'd0);
        check({pfx, "_r_ovl"},    32'(r_overlay),  32'd0);
        check({pfx, "_nevents"},  32'(nevents),    32'd0);
        check({pfx, "_empty"},    32'(empty),      32'd1);
        check({pfx, "_full"},     32'(full),       32'd0);
        check({pfx, "_psize"},    32'(page_size),  32'd0);
        check({pfx, "_ack"},      32'(cfg_ack),    32'd0);
        check({pfx, "_draining"}, 32'(draining),   32'd0);
        check({pfx, "_drops"},    32'(drop_count), 32'd0);
        check({pfx, "_uflow"},    32'(underflow),  32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_values("rst");

        // Fill at 512-word pages: 63 of 64 pages usable.
        for (int i = 0; i < 63; i++) step(1, 0, 0, 0, 2'd0);
        check("fill_nevents", 32'(nevents),   32'd63);
        check("fill_full",    32'(full),      32'd1);
        check("fill_w_id",    32'(w_buf_id),  32'd63);
        check("fill_r_id",    32'(r_buf_id),  32'd0);
        check("fill_w_ovl",   32'(w_overlay), 32'h3f);
        step(1, 0, 0, 0, 2'd0);
        check("fill_drop",    32'(drop_count), 32'd1);
        check("fill_w_hold",  32'(w_buf_id),   32'd63);

        step(0, 0, 1, 0, 2'd0);
        check("clr1_w_id",  32'(w_buf_id),   32'd0);
        check("clr1_drops", 32'(drop_count), 32'd0);

        // Reconfigure to 1024-word pages with a 5-event backlog.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 2'd0);
        step(0, 0, 0, 1, 2'd1);
        check("rcfg_draining0", 32'(draining), 32'd1);
        step(1, 0, 0, 0, 2'd0);
        step(1, 0, 0, 0, 2'd0);
        check("rcfg_drops",     32'(drop_count), 32'd2);
        check("rcfg_w_hold",    32'(w_buf_id),   32'd5);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 2'd0);
            check("rcfg_draining", 32'(draining), 32'd1);
            check("rcfg_no_ack",   32'(cfg_ack),  32'd0);
        end
        step(0, 1, 0, 0, 2'd0);
        check("rcfg_empty",     32'(empty),    32'd1);
        check("rcfg_apply_ack", 32'(cfg_ack),  32'd0);
        check("rcfg_apply_drn", 32'(draining), 32'd0);
        step(0, 0, 0, 0, 2'd0);
        check("rcfg_ack",    32'(cfg_ack),   32'd1);
        check("rcfg_psize",  32'(page_size), 32'd1);
        check("rcfg_w_id",   32'(w_buf_id),  32'd0);
        check("rcfg_r_id",   32'(r_buf_id),  32'd0);
        step(0, 0, 0, 0, 2'd0);
        check("rcfg_ack_once", 32'(cfg_ack), 32'd0);

        // Full at 32 pages, then simultaneous write+read.
        for (int i = 0; i < 31; i++) step(1, 0, 0, 0, 2'd0);
        check("s1_nevents", 32'(nevents),   32'd31);
        check("s1_full",    32'(full),      32'd1);
        check("s1_w_ovl",   32'(w_overlay), 32'h3e);
        step(1, 1, 0, 0, 2'd0);
        check("sim_r_id",    32'(r_buf_id),   32'd1);
        check("sim_w_id",    32'(w_buf_id),   32'd31);
        check("sim_drops",   32'(drop_count), 32'd3);
        check("sim_nevents", 32'(nevents),    32'd30);
        check("sim_full",    32'(full),       32'd0);

        // Drain 30 pages and switch to 2048-word pages.
        step(0, 0, 0, 1, 2'd2);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 2'd0);
        check("s2_drained", 32'(empty), 32'd1);
        step(0, 0, 0, 0, 2'd0);
        check("s2_ack",   32'(cfg_ack),   32'd1);
        check("s2_psize", 32'(page_size), 32'd2);

        // Wrap at 16 pages: one event of lead, then 40 simultaneous cycles.
        step(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 2'd0);
        check("wrap_w_id",    32'(w_buf_id),  32'd9);
        check("wrap_r_id",    32'(r_buf_id),  32'd8);
        check("wrap_w_ovl",   32'(w_overlay), 32'h24);
        check("wrap_r_ovl",   32'(r_overlay), 32'h20);
        check("wrap_nevents", 32'(nevents),   32'd1);
        check("wrap_uflow",   32'(underflow), 32'd0);

        // Underflow, then clear while draining.
        step(0, 1, 0, 0, 2'd0);
        check("uf_empty", 32'(empty), 32'd1);
        step(0, 1, 0, 0, 2'd0);
        check("uf_flag",  32'(underflow), 32'd1);
        check("uf_r_id",  32'(r_buf_id),  32'd9);
        step(0, 0, 0, 1, 2'd1);
        check("clr_in_drain", 32'(draining), 32'd1);
        step(0, 0, 1, 0, 2'd0);
        check("clr_draining", 32'(draining),   32'd0);
        check("clr_uflow",    32'(underflow),  32'd0);
        check("clr_drops",    32'(drop_count), 32'd0);
        check("clr_psize",    32'(page_size),  32'd2);
        check("clr_r_id",     32'(r_buf_id),   32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 2'd0);
            check("clr_no_ack", 32'(cfg_ack), 32'd0);
        end
        step(1, 0, 0, 0, 2'd0);
        check("clr_run_w_id", 32'(w_buf_id), 32'd1);

        // Asynchronous reset between edges with 10 pages occupied.
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 2'd0);
        check("ar_nevents", 32'(nevents), 32'd10);
        #2 reset = 1'b1;
        #1;
        check_reset_values("arst");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Size code 3 is stored as 2.
        step(0, 0, 0, 1, 2'd3);
        step(0, 0, 0, 0, 2'd0);
        step(0, 0, 0, 0, 2'd0);
        check("map3_ack",   32'(cfg_ack),   32'd1);
        check("map3_psize", 32'(page_size), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
